btb_assoc_predictor: RTL and testbench
======================================

// Module: btb_assoc_predictor
// PURPOSE
//  Parametrised N-way set-associative branch target buffer with a 2-bit saturating counter per entry.
//  Sits in the IF stage: it is looked up with next_pc, and the prediction for pc is valid one cycle later.
//  It is trained from EX on every resolved conditional branch.
//  Adds over the direct-mapped BHT/BTT: partial tags, valid bits, way allocation, round-robin replacement and a sequential flush sweep.
// PARAMETERS
//  ADDR_WIDTH  32  PC / target width
//  SETS        64  number of sets, power of 2, >=2; IDX_W = $clog2(SETS)
//  WAYS        2   associativity: 1, 2 or 4
//  TAG_W       10  tag bits = pc[TAG_W+IDX_W+1 : IDX_W+2]
// PORTS
//  cpu_clk            in   1           clock
//  cpu_rst            in   1           reset, synchronous, active-high
//  next_pc            in   ADDR_WIDTH  lookup address, indexes the set
//  pc                 in   ADDR_WIDTH  fetch PC (next_pc of the previous cycle), tag-compared
//  predict_hit        out  1           pc tag-hit in a valid way
//  predict_taken      out  1           predict_hit & counter[1]
//  predict_target_pc  out  ADDR_WIDTH  target of the hit way; 0 on miss
//  upd_valid          in   1           conditional branch resolved in EX this cycle
//  upd_pc             in   ADDR_WIDTH  PC of the resolved branch
//  upd_taken          in   1           actual outcome
//  upd_target         in   ADDR_WIDTH  actual target
//  flush_req          in   1           invalidate all entries (e.g. fence.i)
//  flush_busy         out  1           flush sweep in progress
// BEHAVIOUR
//  Storage
//  - Valid bits, counters and replacement pointers are flops. Tag and target arrays are never reset.
//  Lookup
//  - Cycle t: the set next_pc[IDX_W+1:2] is read into a register.
//  - Cycle t+1: outputs are combinational from that register and pc. At most one way matches.
//  - On a miss, predict_taken and predict_target_pc are 0.
//  Update, when upd_valid and FSM is IDLE; the set is indexed by upd_pc
//  - Tag hit in way w: counter saturates up if taken, down if not taken (00 and 11 are sticky). Target is overwritten only if taken.
//  - Miss and taken: allocate. Use the lowest-index invalid way; if none, use the set's round-robin pointer, which then increments mod WAYS. Write tag and target, valid=1, counter=2'b10.
//  - Miss and not taken: no change.
//  - The round-robin pointer advances only on a replacement of a valid way.
//  - Update and lookup to the same set in the same cycle: the lookup register captures pre-update contents (read-before-write). The new data is visible from the next lookup.
//  Flush FSM
//  - IDLE --flush_req--> SWEEP.
//  - SWEEP clears the valid bits and round-robin pointer of set cnt, one set per cycle, for cnt = 0..SETS-1. After set SETS-1 it returns to IDLE.
//  - flush_busy is 1 exactly in SWEEP, i.e. SETS cycles.
//  - In SWEEP: predict_hit = 0, upd_valid is ignored, flush_req is ignored.
//  - A lookup register loaded before the sweep must not produce a hit while flush_busy=1.
//  Reset
//  - All valids, counters and pointers are cleared; FSM goes to IDLE; the sweep count goes to 0; the lookup register is cleared.
//  - From the cycle after reset, all outputs are 0.
//  - Reset during SWEEP aborts the sweep with the whole table invalid.
//  Widths: counter arithmetic is 2-bit saturating; no wrap.
// TESTING (SETS=64, WAYS=2, TAG_W=10)
//  1 Reset; next_pc=0x100, then pc=0x100 -> hit=0, taken=0, target=0.
//  2 upd pc=0x100 taken, tgt=0x180; lookup 0x100 -> hit=1, taken=1, target=0x180. Two not-taken upds -> hit=1, taken=0 (ctr=00).
//  3 Saturation: 4 taken upds on 0x100 -> ctr=11; 1 not-taken -> taken still 1; 2nd not-taken -> taken=0.
//  4 Aliasing in set 0: taken upds 0x100 (way0), 0x200 (way1), 0x300 (replaces way0, ptr->1) -> 0x100 misses, 0x200 and 0x300 hit; a further 0x400 evicts 0x200.
//  5 flush_req for 1 cycle -> flush_busy=1 for exactly 64 cycles; an upd during the sweep is dropped; afterwards every lookup misses.
//  6 Same-cycle upd and lookup of 0x100 (tgt 0x180 -> 0x1C0): that lookup returns 0x180, the next returns 0x1C0. cpu_rst at sweep cycle 10 -> flush_busy=0 and all miss next cycle.

Source files
------------

// File: rtl/btb_assoc_predictor.sv
// N-way set-associative branch target buffer with 2-bit saturating counters,
// round-robin replacement and a one-set-per-cycle flush sweep.
module btb_assoc_predictor #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned SETS       = 64,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned TAG_W      = 10
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,
  input  logic [ADDR_WIDTH-1:0] next_pc,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic                  predict_hit,
  output logic                  predict_taken,
  output logic [ADDR_WIDTH-1:0] predict_target_pc,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic                  upd_taken,
  input  logic [ADDR_WIDTH-1:0] upd_target,
  input  logic                  flush_req,
  output logic                  flush_busy
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

  // Table storage: valid/counter/pointer are reset, tag/target are not
  logic                  r_valid [SETS][WAYS];
  logic [1:0]            r_ctr   [SETS][WAYS];
  logic [WAY_W-1:0]      r_rr    [SETS];
  logic [TAG_W-1:0]      r_tag   [SETS][WAYS];
  logic [ADDR_WIDTH-1:0] r_tgt   [SETS][WAYS];

  // Lookup register: one whole set captured at next_pc time
  logic                  r_lk_valid [WAYS];
  logic [1:0]            r_lk_ctr   [WAYS];
  logic [TAG_W-1:0]      r_lk_tag   [WAYS];
  logic [ADDR_WIDTH-1:0] r_lk_tgt   [WAYS];

  state_t                r_state;
  logic [IDX_W-1:0]      r_cnt;

  logic [IDX_W-1:0]      w_lk_idx;
  logic [TAG_W-1:0]      w_pc_tag;
  logic [IDX_W-1:0]      w_upd_idx;
  logic [TAG_W-1:0]      w_upd_tag;
  logic                  w_upd_en;
  logic                  w_sweep;
  logic                  w_upd_hit;
  logic [WAY_W-1:0]      w_hit_way;
  logic                  w_has_inv;
  logic [WAY_W-1:0]      w_inv_way;
  logic [WAY_W-1:0]      w_alloc_way;
  logic [WAY_W-1:0]      w_rr_next;
  logic [1:0]            w_ctr_cur;
  logic [1:0]            w_ctr_next;
  logic                  w_unused_bits;

  assign w_lk_idx    = next_pc[IDX_W+1:2];
  assign w_pc_tag    = pc[TAG_W+IDX_W+1:IDX_W+2];
  assign w_upd_idx   = upd_pc[IDX_W+1:2];
  assign w_upd_tag   = upd_pc[TAG_W+IDX_W+1:IDX_W+2];
  assign w_sweep     = (r_state == ST_SWEEP);
  assign w_upd_en    = upd_valid && !w_sweep;
  assign flush_busy  = w_sweep;
  assign w_unused_bits = ^{next_pc, pc, upd_pc};

  // Update-side tag match and lowest-index free way
  always_comb begin
    w_upd_hit = 1'b0;
    w_hit_way = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_upd_idx][w] && (r_tag[w_upd_idx][w] == w_upd_tag)) begin
        w_upd_hit = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!r_valid[w_upd_idx][w]) begin
        w_has_inv = 1'b1;
        w_inv_way = WAY_W'(w);
      end
    end
  end

  assign w_alloc_way = w_has_inv ? w_inv_way : r_rr[w_upd_idx];
  assign w_rr_next   = (r_rr[w_upd_idx] == WAY_W'(WAYS - 1)) ? '0
                                                             : r_rr[w_upd_idx] + WAY_W'(1);
  assign w_ctr_cur   = r_ctr[w_upd_idx][w_hit_way];

  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (upd_taken) begin
      if (w_ctr_cur != 2'b11) w_ctr_next = w_ctr_cur + 2'd1;
    end else begin
      if (w_ctr_cur != 2'b00) w_ctr_next = w_ctr_cur - 2'd1;
    end
  end

  // Control state, valid/counter/pointer training, flush sweep, lookup register
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_rr[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_ctr[s][w]   <= 2'b00;
        end
      end
      for (int w = 0; w < WAYS; w++) begin
        r_lk_valid[w] <= 1'b0;
        r_lk_ctr[w]   <= 2'b00;
        r_lk_tag[w]   <= '0;
        r_lk_tgt[w]   <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (flush_req) begin
            r_state <= ST_SWEEP;
            r_cnt   <= '0;
          end
          if (w_upd_en) begin
            if (w_upd_hit) begin
              r_ctr[w_upd_idx][w_hit_way] <= w_ctr_next;
            end else if (upd_taken) begin
              r_valid[w_upd_idx][w_alloc_way] <= 1'b1;
              r_ctr[w_upd_idx][w_alloc_way]   <= 2'b10;
              if (!w_has_inv) r_rr[w_upd_idx] <= w_rr_next;
            end
          end
        end
        ST_SWEEP: begin
          r_rr[r_cnt] <= '0;
          for (int w = 0; w < WAYS; w++) r_valid[r_cnt][w] <= 1'b0;
          if (r_cnt == IDX_W'(SETS - 1)) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + IDX_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // A set read while sweeping may predate its clear, so it is captured invalid
      for (int w = 0; w < WAYS; w++) begin
        r_lk_valid[w] <= r_valid[w_lk_idx][w] && !w_sweep;
        r_lk_ctr[w]   <= r_ctr[w_lk_idx][w];
        r_lk_tag[w]   <= r_tag[w_lk_idx][w];
        r_lk_tgt[w]   <= r_tgt[w_lk_idx][w];
      end
    end
  end

  // Tag and target arrays carry no reset
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst && w_upd_en && upd_taken) begin
      if (w_upd_hit) begin
        r_tgt[w_upd_idx][w_hit_way] <= upd_target;
      end else begin
        r_tag[w_upd_idx][w_alloc_way] <= w_upd_tag;
        r_tgt[w_upd_idx][w_alloc_way] <= upd_target;
      end
    end
  end

  // Prediction from the captured set; suppressed while the sweep runs
  always_comb begin
    predict_hit       = 1'b0;
    predict_taken     = 1'b0;
    predict_target_pc = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_sweep && r_lk_valid[w] && (r_lk_tag[w] == w_pc_tag)) begin
        predict_hit       = 1'b1;
        predict_taken     = predict_taken | r_lk_ctr[w][1];
        predict_target_pc = predict_target_pc | r_lk_tgt[w];
      end
    end
  end

endmodule

// File: tb/tb_btb_assoc_predictor.sv
// Bench for btb_assoc_predictor: directed scenarios plus random traffic checked
// against a per-entry reference model of the buffer.
module tb_btb_assoc_predictor;

  localparam int SETS = 64;
  localparam int WAYS = 2;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b1;
  logic [31:0] next_pc = '0;
  logic [31:0] pc = '0;
  logic        predict_hit;
  logic        predict_taken;
  logic [31:0] predict_target_pc;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        flush_req = 1'b0;
  logic        flush_busy;

  btb_assoc_predictor #(.ADDR_WIDTH(32), .SETS(SETS), .WAYS(WAYS), .TAG_W(10)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .next_pc(next_pc), .pc(pc),
    .predict_hit(predict_hit), .predict_taken(predict_taken),
    .predict_target_pc(predict_target_pc), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .flush_req(flush_req),
    .flush_busy(flush_busy)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Reference model: one record per (set, way)
  bit          m_valid [SETS][WAYS];
  int          m_tag   [SETS][WAYS];
  logic [31:0] m_tgt   [SETS][WAYS];
  int          m_ctr   [SETS][WAYS];
  int          m_rr    [SETS];
  bit          m_busy;
  int          m_cnt;

  int          vectors = 0;
  int          miscompares = 0;
  bit          chk_en = 0;
  logic [31:0] prev_next = '0;
  logic        e_hit, e_taken, e_busy;
  logic [31:0] e_tgt;
  logic        s_hit, s_taken, s_busy;
  logic [31:0] s_tgt;
  int          busy_cycles;

  function automatic int set_of(input logic [31:0] a);
    return int'((a / 4) % SETS);
  endfunction

  function automatic int tag_of(input logic [31:0] a);
    return int'((a / (4 * SETS)) % 1024);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0; m_ctr[s][w] = 0;
      end
    end
    m_busy = 0; m_cnt = 0;
  endtask

  task automatic model_lookup(input logic [31:0] a, output logic h, output logic t,
                              output logic [31:0] g);
    int s;
    s = set_of(a);
    h = 0; t = 0; g = '0;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == tag_of(a)) begin
        h = 1; t = (m_ctr[s][w] >= 2); g = m_tgt[s][w];
      end
  endtask

  task automatic model_update(input logic [31:0] a, input logic tk, input logic [31:0] g);
    int s, hw, way;
    s = set_of(a);
    hw = -1;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == tag_of(a)) hw = w;
    if (hw >= 0) begin
      m_ctr[s][hw] = tk ? ((m_ctr[s][hw] < 3) ? m_ctr[s][hw] + 1 : 3)
                        : ((m_ctr[s][hw] > 0) ? m_ctr[s][hw] - 1 : 0);
      if (tk) m_tgt[s][hw] = g;
    end else if (tk) begin
      way = -1;
      for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) way = w;
      if (way < 0) begin
        way = m_rr[s];
        m_rr[s] = (m_rr[s] + 1) % WAYS;
      end
      m_valid[s][way] = 1; m_tag[s][way] = tag_of(a); m_tgt[s][way] = g; m_ctr[s][way] = 2;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check the previous cycle's prediction, advance the model
  task automatic cycle(input bit rst, input logic [31:0] n, input bit uv,
                       input logic [31:0] upc, input bit ut, input logic [31:0] utg,
                       input bit fr);
    bit was_busy;
    cpu_rst = rst; pc = prev_next; next_pc = n;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg; flush_req = fr;
    #1;
    s_hit = predict_hit; s_taken = predict_taken; s_tgt = predict_target_pc; s_busy = flush_busy;
    if (chk_en) begin
      check("hit", 32'(predict_hit), 32'(e_hit));
      check("taken", 32'(predict_taken), 32'(e_taken));
      check("target", predict_target_pc, e_tgt);
      check("flush_busy", 32'(flush_busy), 32'(e_busy));
    end
    was_busy = m_busy;
    model_lookup(n, e_hit, e_taken, e_tgt);
    if (rst) begin
      model_reset();
      e_hit = 0; e_taken = 0; e_tgt = '0;
    end else if (m_busy) begin
      m_rr[m_cnt] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[m_cnt][w] = 0;
      if (m_cnt == SETS - 1) begin m_busy = 0; m_cnt = 0; end
      else m_cnt++;
    end else begin
      if (uv) model_update(upc, ut, utg);
      if (fr) begin m_busy = 1; m_cnt = 0; end
    end
    if (was_busy || m_busy) begin e_hit = 0; e_taken = 0; e_tgt = '0; end
    e_busy = m_busy;
    prev_next = n;
    @(posedge cpu_clk); #1;
    if (rst) chk_en = 1;
  endtask

  task automatic look(input logic [31:0] n);
    cycle(0, n, 0, '0, 0, '0, 0);
  endtask

  task automatic upd(input logic [31:0] a, input bit tk, input logic [31:0] g);
    cycle(0, '0, 1, a, tk, g, 0);
  endtask

  // Lookup a then observe its prediction in the following cycle
  task automatic probe(input logic [31:0] a);
    look(a);
    look('0);
  endtask

  initial begin
    logic [31:0] a, g;
    model_reset();
    e_hit = 0; e_taken = 0; e_tgt = '0; e_busy = 0;
    @(posedge cpu_clk); #1;
    cycle(1, '0, 0, '0, 0, '0, 0);
    cycle(1, '0, 0, '0, 0, '0, 0);

    // Empty table misses; train, weaken, saturate
    probe(32'h100);
    upd(32'h100, 1, 32'h180);
    probe(32'h100);
    check("t2_target", s_tgt, 32'h180);
    upd(32'h100, 0, '0);
    upd(32'h100, 0, '0);
    probe(32'h100);
    repeat (4) upd(32'h100, 1, 32'h180);
    probe(32'h100);
    upd(32'h100, 0, '0);
    probe(32'h100);
    upd(32'h100, 0, '0);
    probe(32'h100);
    check("t3_taken_after_2nt", 32'(s_taken), 32'd0);

    // Aliasing and round-robin replacement in set 0
    upd(32'h200, 1, 32'h280);
    upd(32'h300, 1, 32'h380);
    probe(32'h100); probe(32'h200); probe(32'h300);
    upd(32'h400, 1, 32'h480);
    probe(32'h200);
    check("t4_evicted", 32'(s_hit), 32'd0);
    probe(32'h300); probe(32'h400);

    // Flush sweep length, dropped update, everything misses afterwards
    cycle(0, 32'h300, 0, '0, 0, '0, 1);
    busy_cycles = 0;
    for (int i = 0; i < 70; i++) begin
      if (i == 5) upd(32'h500, 1, 32'h580);
      else look(32'h300);
      if (s_busy) busy_cycles++;
    end
    check("t5_busy_cycles", 32'(busy_cycles), 32'd64);
    probe(32'h300); probe(32'h400); probe(32'h500);

    // Read-before-write on a same-cycle update and lookup
    upd(32'h100, 1, 32'h180);
    cycle(0, 32'h100, 1, 32'h100, 1, 32'h1C0, 0);
    look(32'h100);
    check("t6_old_target", s_tgt, 32'h180);
    look('0);
    check("t6_new_target", s_tgt, 32'h1C0);

    // Reset in the middle of a sweep
    cycle(0, '0, 0, '0, 0, '0, 1);
    repeat (10) look(32'h100);
    cycle(1, 32'h100, 0, '0, 0, '0, 0);
    look(32'h100);
    check("t6_busy_after_rst", 32'(s_busy), 32'd0);
    probe(32'h100);

    // Random traffic over a small address pool to force hits, aliasing and eviction
    for (int i = 0; i < 4000; i++) begin
      bit uv, fr, rs;
      a = {20'd0, 4'($urandom_range(0, 5)), 6'($urandom_range(0, 3)), 2'b00};
      g = {$urandom} & 32'hFFFF_FFFC;
      uv = ($urandom_range(0, 1) == 1);
      fr = ($urandom_range(0, 299) == 0);
      rs = ($urandom_range(0, 999) == 0);
      cycle(rs, {20'd0, 4'($urandom_range(0, 5)), 6'($urandom_range(0, 3)), 2'b00},
            uv, a, $urandom_range(0, 2) != 0, g, fr);
    end
    look('0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
